// File: rtl/bcd_scan_counter_pkg.sv
// Shared constants for the BCD scan counter: active-low 7-segment patterns
// (seg[0]=a .. seg[6]=g, seg[7]=dp held off) and the digit-count upper bound.
package bcd_scan_counter_pkg;

    localparam int MAX_DIGITS = 8;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] pat;
        case (nib)
            4'd0:    pat = SEG_0;
            4'd1:    pat = SEG_1;
            4'd2:    pat = SEG_2;
            4'd3:    pat = SEG_3;
            4'd4:    pat = SEG_4;
            4'd5:    pat = SEG_5;
            4'd6:    pat = SEG_6;
            4'd7:    pat = SEG_7;
            4'd8:    pat = SEG_8;
            4'd9:    pat = SEG_9;
            default: pat = SEG_BLANK;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bcd_scan_counter_btn_conditioner.sv
// Button conditioner: 2-flop synchronizer, counting debouncer and a
// registered rising-edge one-shot producing a single-cycle pulse.
module btn_conditioner #(
    parameter int DEB_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_pulse
);

    localparam int CNT_W = $clog2(DEB_CYC + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_deb;
    logic             r_deb_d;
    logic [CNT_W-1:0] r_cnt;
    logic             r_pulse;

    // Synchronize, debounce and edge-detect the raw button.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_deb   <= 1'b0;
            r_deb_d <= 1'b0;
            r_cnt   <= {CNT_W{1'b0}};
            r_pulse <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_deb_d <= r_deb;
            r_pulse <= r_deb & ~r_deb_d;
            // The output flips on the DEB_CYC-th consecutive disagreeing cycle.
            if (r_sync2 != r_deb) begin
                if (r_cnt == CNT_W'(DEB_CYC - 1)) begin
                    r_deb <= r_sync2;
                    r_cnt <= {CNT_W{1'b0}};
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end else begin
                r_cnt <= {CNT_W{1'b0}};
            end
        end
    end

    assign o_pulse = r_pulse;

endmodule

// File: rtl/bcd_scan_counter.sv
// Up/down BCD counter with debounced buttons and a multiplexed 7-segment scan.
// Optional leading-zero blanking is enabled with macro LEADING_ZERO_BLANK_EN.
module bcd_scan_counter
    import bcd_scan_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int CLKSPDMHZ  = 100,
    parameter int DELAYMS    = 5,
    parameter int SCAN_DIV   = 100000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    sw_up,
    input  logic                    sw_dn,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [7:0]              seg,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    wrap
);

    localparam int DEB_CYC = CLKSPDMHZ * 1000 * DELAYMS;
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W   = $clog2(SCAN_DIV);

    logic                    w_up;
    logic                    w_dn;
    logic [4*NUM_DIGITS-1:0] r_count;
    logic [4*NUM_DIGITS-1:0] w_count_nxt;
    logic                    w_carry;
    logic                    r_wrap;
    logic [DIV_W-1:0]        r_div;
    logic [IDX_W-1:0]        r_idx;
    logic [NUM_DIGITS-1:0]   r_an;
    logic [7:0]              r_seg;
    logic [NUM_DIGITS-1:0]   w_blank;
    logic [3:0]              w_digit;

    btn_conditioner #(.DEB_CYC(DEB_CYC)) u_btn_up (
        .clk(clk), .reset(reset), .i_btn(sw_up), .o_pulse(w_up)
    );

    btn_conditioner #(.DEB_CYC(DEB_CYC)) u_btn_dn (
        .clk(clk), .reset(reset), .i_btn(sw_dn), .o_pulse(w_dn)
    );

    // Decimal increment/decrement with ripple carry; leftover carry means wrap.
    always_comb begin
        w_count_nxt = r_count;
        w_carry     = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_carry) begin
                if (w_up) begin
                    if (r_count[4*i +: 4] == 4'd9) begin
                        w_count_nxt[4*i +: 4] = 4'd0;
                    end else begin
                        w_count_nxt[4*i +: 4] = r_count[4*i +: 4] + 4'd1;
                        w_carry = 1'b0;
                    end
                end else begin
                    if (r_count[4*i +: 4] == 4'd0) begin
                        w_count_nxt[4*i +: 4] = 4'd9;
                    end else begin
                        w_count_nxt[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
                        w_carry = 1'b0;
                    end
                end
            end else begin
                w_count_nxt[4*i +: 4] = r_count[4*i +: 4];
            end
        end
    end

    // Count register; coincident up and down pulses cancel.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= {(4*NUM_DIGITS){1'b0}};
            r_wrap  <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            if (w_up ^ w_dn) begin
                r_count <= w_count_nxt;
                r_wrap  <= w_carry;
            end
        end
    end

    // Scan divider and digit index; independent of button activity.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_div <= {DIV_W{1'b0}};
            r_idx <= {IDX_W{1'b0}};
        end else if (r_div == DIV_W'(SCAN_DIV - 1)) begin
            r_div <= {DIV_W{1'b0}};
            if (r_idx == IDX_W'(NUM_DIGITS - 1)) begin
                r_idx <= {IDX_W{1'b0}};
            end else begin
                r_idx <= r_idx + IDX_W'(1);
            end
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic w_higher_zero;

    // A zero digit is blanked when every digit above it is zero too.
    always_comb begin
        w_blank       = {NUM_DIGITS{1'b0}};
        w_higher_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            if (r_count[4*i +: 4] == 4'd0) begin
                if (i != 0) begin
                    w_blank[i] = w_higher_zero;
                end else begin
                    w_blank[i] = 1'b0;
                end
            end else begin
                w_higher_zero = 1'b0;
            end
        end
    end
`else
    assign w_blank = {NUM_DIGITS{1'b0}};
`endif

    assign w_digit = r_count[{r_idx, 2'b00} +: 4];

    // Registered anode and segment drive for the selected digit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an  <= {NUM_DIGITS{1'b1}};
            r_seg <= SEG_BLANK;
        end else begin
            r_an  <= ~(NUM_DIGITS'(1'b1) << r_idx);
            r_seg <= w_blank[r_idx] ? SEG_BLANK : seg_decode(w_digit);
        end
    end

    assign an    = r_an;
    assign seg   = r_seg;
    assign count = r_count;
    assign wrap  = r_wrap;

endmodule
